// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int OFF_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_next.sv
// Next fetch address: sequential increment or PC-relative branch target.
// Both paths wrap silently modulo 2**PC_W.
module fetch_pc_next
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0]  pc_q,
    input  logic [PC_W-1:0]  instr_pc,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             take_branch,
    output logic [PC_W-1:0]  next_pc
);
    logic [PC_W-1:0] offset_sext;

    assign offset_sext = {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};

    always_comb begin
        next_pc = pc_q + PC_W'(1);
        // Branch targets are relative to the decoded instruction, not the fetch address.
        if (take_branch) next_pc = instr_pc + offset_sext;
    end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a sync-read instruction memory and
// presents one instruction per cycle with its PC, handling branch, stall and halt.
module instruction_fetch
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [OFF_W-1:0]   branch_offset,
    input  logic               halt_req,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               done,
    output fetch_state_t       state
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            take_branch;
    logic [PC_W-1:0] next_pc;

    fetch_pc_next u_pc_next (
        .pc_q          (pc_q),
        .instr_pc      (instr_pc_q),
        .branch_offset (branch_offset),
        .take_branch   (take_branch),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        imem_en     = 1'b0;
        take_branch = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                imem_en = !stall;
                if (!stall) begin
                    if (valid_q && halt_req) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else begin
                        // The word already being read after a taken branch becomes a bubble.
                        take_branch = valid_q && branch_taken;
                        pc_d        = next_pc;
                        instr_pc_d  = pc_q;
                        valid_d     = !take_branch;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instruction = imem_rdata;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign done        = (state_q == HALT);
    assign state       = state_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural sync-read memory.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stall;
    logic               branch_taken;
    logic [OFF_W-1:0]   branch_offset;
    logic               halt_req;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               done;
    fetch_state_t       state;

    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    int n_checks;
    int n_fail;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .halt_req      (halt_req),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .done          (done),
        .state         (state)
    );

    // Clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    function automatic logic [INSTR_W-1:0] word_at(input int a);
        int v;
        v = (a * 37 + 11) ^ (a >> 3);
        return v[INSTR_W-1:0];
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step_n(2);
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({imem_addr, instr_pc} !== 20'd0) begin n_fail++; $display("FAIL reset_pcs: got addr %0d pc %0d expected 0 0", imem_addr, instr_pc); end
        reset = 1'b0;
        step();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d expected %0d", state, IDLE); end
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (imem_addr !== 10'd0 || imem_en !== 1'b1) begin n_fail++; $display("FAIL start_addr: got addr %0d en %b expected 0 1", imem_addr, imem_en); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL start_first_valid: got %b expected 0", instr_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr_pc !== PC_W'(k)) begin n_fail++; $display("FAIL seq_pc%0d: got valid %b pc %0d expected 1 %0d", k, instr_valid, instr_pc, k); end
            n_checks++; if (instruction !== word_at(k)) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", k, instruction, word_at(k)); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL seq_done%0d: got %b expected 0", k, done); end
        end
        // start while running is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (instr_pc !== 10'd4 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL start_in_run: got pc %0d valid %b expected 4 1", instr_pc, instr_valid); end
    endtask

    task automatic test_branch_fwd();
        restart();
        step_n(2);
        branch_taken = 1'b1;
        branch_offset = 8'h05;
        step();
        // branch held high through the bubble must be ignored
        branch_offset = 8'h10;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL brf_bubble: got valid %b expected 0", instr_valid); end
        step();
        branch_taken = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd7) begin n_fail++; $display("FAIL brf_target: got valid %b pc %0d expected 1 7", instr_valid, instr_pc); end
        n_checks++; if (instruction !== word_at(7)) begin n_fail++; $display("FAIL brf_instr: got %h expected %h", instruction, word_at(7)); end
        step();
        n_checks++; if (instr_pc !== 10'd8 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL brf_after: got pc %0d valid %b expected 8 1", instr_pc, instr_valid); end
    endtask

    task automatic test_branch_back_and_wrap();
        restart();
        step_n(4);
        branch_taken = 1'b1;
        branch_offset = 8'hFE;
        step();
        branch_taken = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL brb_bubble: got valid %b expected 0", instr_valid); end
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd2) begin n_fail++; $display("FAIL brb_target: got valid %b pc %0d expected 1 2", instr_valid, instr_pc); end
        restart();
        branch_taken = 1'b1;
        branch_offset = 8'h80;
        step();
        branch_taken = 1'b0;
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd896) begin n_fail++; $display("FAIL brw_target: got valid %b pc %0d expected 1 896", instr_valid, instr_pc); end
        n_checks++; if (instruction !== word_at(896)) begin n_fail++; $display("FAIL brw_instr: got %h expected %h", instruction, word_at(896)); end
    endtask

    task automatic test_stall();
        restart();
        step_n(5);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_offset = 8'h20;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (instr_pc !== 10'd5 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got pc %0d valid %b expected 5 1", k, instr_pc, instr_valid); end
            n_checks++; if (instruction !== word_at(5)) begin n_fail++; $display("FAIL stall_instr%0d: got %h expected %h", k, instruction, word_at(5)); end
            n_checks++; if (imem_en !== 1'b0 || imem_addr !== 10'd6) begin n_fail++; $display("FAIL stall_mem%0d: got en %b addr %0d expected 0 6", k, imem_en, imem_addr); end
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        n_checks++; if (instr_pc !== 10'd6 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got pc %0d valid %b expected 6 1", instr_pc, instr_valid); end
        n_checks++; if (instruction !== word_at(6)) begin n_fail++; $display("FAIL stall_rel_instr: got %h expected %h", instruction, word_at(6)); end
    endtask

    task automatic test_halt();
        restart();
        step_n(9);
        halt_req = 1'b1;
        branch_taken = 1'b1;
        branch_offset = 8'h05;
        step();
        halt_req = 1'b0;
        branch_taken = 1'b0;
        n_checks++; if (state !== HALT || done !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got state %0d done %b expected %0d 1", state, done, HALT); end
        n_checks++; if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin n_fail++; $display("FAIL halt_outputs: got valid %b en %b expected 0 0", instr_valid, imem_en); end
        stall = 1'b1;
        step();
        stall = 1'b0;
        n_checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_stay: got done %b valid %b expected 1 0", done, instr_valid); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b0 || imem_addr !== 10'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_restart: got done %b addr %0d valid %b expected 0 0 0", done, imem_addr, instr_valid); end
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd0) begin n_fail++; $display("FAIL halt_first: got valid %b pc %0d expected 1 0", instr_valid, instr_pc); end
        n_checks++; if (instruction !== word_at(0)) begin n_fail++; $display("FAIL halt_instr: got %h expected %h", instruction, word_at(0)); end
    endtask

    task automatic test_wrap_and_reset();
        restart();
        step_n(1023);
        n_checks++; if (instr_pc !== 10'd1023 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_top: got pc %0d valid %b expected 1023 1", instr_pc, instr_valid); end
        step();
        n_checks++; if (instr_pc !== 10'd0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got pc %0d valid %b expected 0 1", instr_pc, instr_valid); end
        n_checks++; if (instruction !== word_at(0)) begin n_fail++; $display("FAIL wrap_instr: got %h expected %h", instruction, word_at(0)); end
        step_n(3);
        reset = 1'b1;
        start = 1'b1;
        halt_req = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        n_checks++; if (state !== IDLE || instr_valid !== 1'b0 || imem_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got state %0d valid %b en %b done %b expected %0d 0 0 0", state, instr_valid, imem_en, done, IDLE); end
        n_checks++; if (imem_addr !== 10'd0 || instr_pc !== 10'd0) begin n_fail++; $display("FAIL midrun_reset_pc: got addr %0d pc %0d expected 0 0", imem_addr, instr_pc); end
    endtask

    // Final report
    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_offset = '0;
        halt_req = 1'b0;
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = word_at(i);
        test_reset();
        test_start();
        test_branch_fwd();
        test_branch_back_and_wrap();
        test_stall();
        test_halt();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
